axis_burst_pad: RTL and testbench

- Sits directly upstream of the AXIS-to-AXI-MM burst writer, on its s_axis input.
- The writer only ends a transfer on a burst boundary, so this block pads every AXIS packet with filler beats up to the next multiple of BURST_LEN.
- TLAST is moved to the final beat of that padded burst.
- Reports the original packet length and the pad count per packet, so software can recover true payload size.

---
 rtl/axis_burst_pkg.sv | 24 ++
 rtl/axis_burst_pad_out_reg.sv | 52 +++++
 rtl/axis_burst_pad.sv | 138 +++++++++++++
 tb/tb_axis_burst_pad.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_burst_pkg.sv
// Shared definitions for the AXIS burst padder and the AXIS-to-AXI-MM
// burst writer it feeds.
//   pad_state_t       : padder FSM states (PASS streams input, PAD emits filler)
//   beat_cnt_width()  : width of the in-burst beat position counter
//   burst_len_legal() : burst-length legality check used by both blocks
package axis_burst_pkg;

    typedef enum logic {
        PASS = 1'b0,
        PAD  = 1'b1
    } pad_state_t;

    localparam int MAX_BURST_LEN = 256;

    // A single-beat burst still needs a one-bit counter.
    function automatic int beat_cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

    function automatic bit burst_len_legal(input int burst_len);
        return (burst_len >= 1) && (burst_len <= MAX_BURST_LEN);
    endfunction

endpackage

// File: rtl/axis_burst_pad_out_reg.sv
// One-deep valid/ready output register carrying data + last.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load_vld            : a beat is offered for loading this cycle
//   load_data/load_last : payload of the offered beat
//   load_en             : register can take a beat this cycle
//   tdata/tlast/tvalid  : registered stream outputs
//   tready              : downstream accepts the current beat
module axis_out_reg
    import axis_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_vld,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_en,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tlast,
    output logic                  tvalid,
    input  logic                  tready
);

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  last_p1;
    logic                  vld_p1;

    // Empty or draining this cycle: safe to overwrite the held beat.
    assign load_en = !vld_p1 || tready;

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (load_en) begin
            vld_p1 <= load_vld;
            if (load_vld) begin
                data_p1 <= load_data;
                last_p1 <= load_last;
            end
        end
    end

    assign tdata  = data_p1;
    assign tlast  = last_p1;
    assign tvalid = vld_p1;

endmodule

// File: rtl/axis_burst_pad.sv
// Pads every AXIS packet with PAD_VALUE beats up to the next multiple of
// BURST_LEN and moves TLAST to the final beat of the padded burst, so the
// downstream burst writer always ends on a burst boundary. Reports the real
// packet length and the number of filler beats once per packet.
// Ports:
//   ACLK, ARESET                 : clock, synchronous active-high reset
//   s_axis_tdata/tlast/tvalid    : input stream
//   s_axis_tready                : input beat accepted
//   m_axis_tdata/tlast/tvalid    : padded output stream (registered)
//   m_axis_tready                : downstream ready
//   pkt_len, pad_beats           : real length / filler count of last packet
//   pkt_len_valid                : one-cycle strobe for pkt_len/pad_beats
//   busy                         : inside a packet, padding, or beat pending
module axis_burst_pad
    import axis_burst_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BURST_LEN  = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
    parameter int                    LEN_WIDTH  = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [7:0]            pad_beats,
    output logic                  pkt_len_valid,
    output logic                  busy
);

    localparam int                BEAT_W    = beat_cnt_width(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    generate
        if (!burst_len_legal(BURST_LEN)) begin : g_bad_burst_len
            $error("axis_burst_pad: BURST_LEN must be in 1..256");
        end
    endgenerate

    pad_state_t            state;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [LEN_WIDTH-1:0]  len_cnt;

    logic                  load_en;
    logic                  load_vld;
    logic                  load_last;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  accept;
    logic                  at_last_beat;

    // With BURST_LEN==1 the counter is pinned at 0, so every beat is last.
    assign at_last_beat  = (beat_cnt == LAST_BEAT);
    assign s_axis_tready = (state == PASS) && load_en;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // ---- stage p0: select the beat offered to the output register ----
    always_comb begin
        load_vld  = 1'b0;
        load_data = PAD_VALUE;
        load_last = 1'b0;
        if (state == PASS) begin
            load_vld  = accept;
            load_data = s_axis_tdata;
            load_last = s_axis_tlast && at_last_beat;
        end else begin
            load_vld  = 1'b1;
            load_last = at_last_beat;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= PASS;
            beat_cnt      <= '0;
            len_cnt       <= '0;
            pkt_len_valid <= 1'b0;
            pkt_len       <= '0;
            pad_beats     <= '0;
        end else begin
            pkt_len_valid <= 1'b0;

            // Position tracks output beats, real or filler alike.
            if (load_en && load_vld) begin
                beat_cnt <= at_last_beat ? '0 : beat_cnt + 1'b1;
            end

            case (state)
                PASS: begin
                    if (accept) begin
                        if (s_axis_tlast) begin
                            pkt_len_valid <= 1'b1;
                            pkt_len       <= len_cnt + 1'b1;
                            pad_beats     <= 8'(LAST_BEAT - beat_cnt);
                            len_cnt       <= '0;
                            if (!at_last_beat) begin
                                state <= PAD;
                            end
                        end else begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (load_en && at_last_beat) begin
                        state <= PASS;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

    // ---- stage p1: output register ----
    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (ACLK),
        .rst      (ARESET),
        .load_vld (load_vld),
        .load_data(load_data),
        .load_last(load_last),
        .load_en  (load_en),
        .tdata    (m_axis_tdata),
        .tlast    (m_axis_tlast),
        .tvalid   (m_axis_tvalid),
        .tready   (m_axis_tready)
    );

    assign busy = (state == PAD) || (len_cnt != '0) || m_axis_tvalid;

endmodule

// File: tb/tb_axis_burst_pad.sv
module tb_axis_burst_pad;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT A: BURST_LEN=16
    logic [31:0] a_s_tdata, a_m_tdata, a_pkt_len;
    logic        a_s_tlast, a_s_tvalid, a_s_tready;
    logic        a_m_tlast, a_m_tvalid, a_m_tready;
    logic [7:0]  a_pad;
    logic        a_plv, a_busy;
    // DUT B: BURST_LEN=1
    logic [31:0] b_s_tdata, b_m_tdata, b_pkt_len;
    logic        b_s_tlast, b_s_tvalid, b_s_tready;
    logic        b_m_tlast, b_m_tvalid, b_m_tready;
    logic [7:0]  b_pad;
    logic        b_plv, b_busy;

    axis_burst_pad #(.DATA_WIDTH(32), .BURST_LEN(16), .PAD_VALUE(32'h0), .LEN_WIDTH(32)) dut_a (
        .ACLK(clk), .ARESET(rst),
        .s_axis_tdata(a_s_tdata), .s_axis_tlast(a_s_tlast), .s_axis_tvalid(a_s_tvalid),
        .s_axis_tready(a_s_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tlast(a_m_tlast), .m_axis_tvalid(a_m_tvalid),
        .m_axis_tready(a_m_tready),
        .pkt_len(a_pkt_len), .pad_beats(a_pad), .pkt_len_valid(a_plv), .busy(a_busy)
    );

    axis_burst_pad #(.DATA_WIDTH(32), .BURST_LEN(1), .PAD_VALUE(32'h0), .LEN_WIDTH(32)) dut_b (
        .ACLK(clk), .ARESET(rst),
        .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast), .s_axis_tvalid(b_s_tvalid),
        .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tready(b_m_tready),
        .pkt_len(b_pkt_len), .pad_beats(b_pad), .pkt_len_valid(b_plv), .busy(b_busy)
    );

    int          tests = 0;
    int          fails = 0;
    beat_t       in_q[$];
    beat_t       out_q[$];
    logic [39:0] len_q[$];
    beat_t       exp_q[$];
    int          low_cnt;
    int          stall_err;
    bit          hold_vld;
    beat_t       hold_beat;

    // One cycle: drive at negedge, sample #1 later (what the next posedge sees).
    task automatic step(input bit sel, input bit rnd, input bit idle);
        logic  mr, sv, st, mv;
        beat_t mb, ib;
        @(negedge clk);
        mr = (rnd && !idle) ? 1'($urandom_range(0, 1)) : 1'b1;
        sv = !idle && (in_q.size() > 0);
        ib = '0;
        if (sv) ib = in_q[0];
        if (!sel) begin
            a_m_tready = mr; a_s_tvalid = sv; a_s_tdata = ib.data; a_s_tlast = ib.last;
        end else begin
            b_m_tready = mr; b_s_tvalid = sv; b_s_tdata = ib.data; b_s_tlast = ib.last;
        end
        #1;
        if (!sel) begin
            st = a_s_tready; mv = a_m_tvalid; mb = {a_m_tlast, a_m_tdata};
            if (a_plv) len_q.push_back({a_pkt_len, a_pad});
        end else begin
            st = b_s_tready; mv = b_m_tvalid; mb = {b_m_tlast, b_m_tdata};
            if (b_plv) len_q.push_back({b_pkt_len, b_pad});
        end
        if (sv && st) ib = in_q.pop_front();
        if (hold_vld && (!mv || mb !== hold_beat)) stall_err++;
        hold_vld  = mv && !mr;
        hold_beat = mb;
        if (mv && mr) out_q.push_back(mb);
        if (mr && !st) low_cnt++;
    endtask

    task automatic drive(input bit sel, input int n_out, input bit rnd, input int idle_n);
        int cyc = 0;
        out_q.delete(); len_q.delete();
        low_cnt = 0; stall_err = 0; hold_vld = 0;
        while ((in_q.size() > 0 || out_q.size() < n_out) && cyc < 3000) begin
            step(sel, rnd, 1'b0);
            cyc++;
        end
        if (cyc >= 3000) begin
            tests++; fails++;
            $display("FAIL drive_timeout beats got %0d need %0d", out_q.size(), n_out);
        end
        repeat (idle_n) step(sel, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (a_m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_m_tvalid got %b need 0", a_m_tvalid); end
        tests++; if (a_m_tlast !== 1'b0) begin fails++; $display("FAIL rst_m_tlast got %b need 0", a_m_tlast); end
        tests++; if (a_m_tdata !== 32'h0) begin fails++; $display("FAIL rst_m_tdata got %h need 0", a_m_tdata); end
        tests++; if (a_plv !== 1'b0) begin fails++; $display("FAIL rst_pkt_len_valid got %b need 0", a_plv); end
        tests++; if (a_pkt_len !== 32'h0) begin fails++; $display("FAIL rst_pkt_len got %0d need 0", a_pkt_len); end
        tests++; if (a_pad !== 8'h0) begin fails++; $display("FAIL rst_pad_beats got %0d need 0", a_pad); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b need 0", a_busy); end
        tests++; if (a_s_tready !== 1'b1) begin fails++; $display("FAIL rst_s_tready got %b need 1", a_s_tready); end
        tests++; if (b_m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_b_m_tvalid got %b need 0", b_m_tvalid); end
    endtask

    task automatic test_full_burst();
        beat_t act;
        in_q.delete(); exp_q.delete();
        for (int i = 1; i <= 16; i++) begin
            in_q.push_back({(i == 16), 32'(i)});
            exp_q.push_back({(i == 16), 32'(i)});
        end
        drive(1'b0, 16, 1'b0, 3);
        tests++; if (out_q.size() != 16) begin fails++; $display("FAIL full_count got %0d need 16", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            act = 'x; if (i < out_q.size()) act = out_q[i];
            tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL full_beat%0d got %h need %h", i, act, exp_q[i]); end
        end
        tests++; if (len_q.size() != 1 || len_q[0] !== {32'd16, 8'd0}) begin
            fails++; $display("FAIL full_len pulses %0d got %h need %h", len_q.size(), (len_q.size() > 0) ? len_q[0] : 40'h0, {32'd16, 8'd0});
        end
        tests++; if (low_cnt != 0) begin fails++; $display("FAIL full_pad_cycles got %0d need 0", low_cnt); end
    endtask

    task automatic test_short_pad();
        beat_t act;
        in_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            in_q.push_back({(i == 4), 32'hA0 + 32'(i)});
            exp_q.push_back({1'b0, 32'hA0 + 32'(i)});
        end
        for (int i = 0; i < 11; i++) exp_q.push_back({(i == 10), 32'h0});
        drive(1'b0, 16, 1'b0, 3);
        tests++; if (out_q.size() != 16) begin fails++; $display("FAIL short_count got %0d need 16", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            act = 'x; if (i < out_q.size()) act = out_q[i];
            tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL short_beat%0d got %h need %h", i, act, exp_q[i]); end
        end
        tests++; if (len_q.size() != 1 || len_q[0] !== {32'd5, 8'd11}) begin
            fails++; $display("FAIL short_len pulses %0d got %h need %h", len_q.size(), (len_q.size() > 0) ? len_q[0] : 40'h0, {32'd5, 8'd11});
        end
        tests++; if (low_cnt != 11) begin fails++; $display("FAIL short_tready_low got %0d need 11", low_cnt); end
    endtask

    task automatic test_two_bursts();
        beat_t act;
        in_q.delete(); exp_q.delete();
        for (int i = 0; i < 21; i++) begin
            in_q.push_back({(i == 20), 32'h300 + 32'(i)});
            exp_q.push_back({1'b0, 32'h300 + 32'(i)});
        end
        for (int i = 0; i < 11; i++) exp_q.push_back({(i == 10), 32'h0});
        drive(1'b0, 32, 1'b0, 3);
        tests++; if (out_q.size() != 32) begin fails++; $display("FAIL two_count got %0d need 32", out_q.size()); end
        for (int i = 0; i < 32; i++) begin
            act = 'x; if (i < out_q.size()) act = out_q[i];
            tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL two_beat%0d got %h need %h", i, act, exp_q[i]); end
        end
        tests++; if (len_q.size() != 1 || len_q[0] !== {32'd21, 8'd11}) begin
            fails++; $display("FAIL two_len pulses %0d got %h need %h", len_q.size(), (len_q.size() > 0) ? len_q[0] : 40'h0, {32'd21, 8'd11});
        end
    endtask

    task automatic test_back_to_back();
        beat_t act;
        in_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            in_q.push_back({(i == 2), 32'h100 + 32'(i)});
            exp_q.push_back({1'b0, 32'h100 + 32'(i)});
        end
        for (int i = 0; i < 13; i++) exp_q.push_back({(i == 12), 32'h0});
        for (int i = 0; i < 17; i++) begin
            in_q.push_back({(i == 16), 32'h200 + 32'(i)});
            exp_q.push_back({1'b0, 32'h200 + 32'(i)});
        end
        for (int i = 0; i < 15; i++) exp_q.push_back({(i == 14), 32'h0});
        drive(1'b0, 48, 1'b1, 4);
        tests++; if (out_q.size() != 48) begin fails++; $display("FAIL b2b_count got %0d need 48", out_q.size()); end
        for (int i = 0; i < 48; i++) begin
            act = 'x; if (i < out_q.size()) act = out_q[i];
            tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL b2b_beat%0d got %h need %h", i, act, exp_q[i]); end
        end
        tests++; if (stall_err != 0) begin fails++; $display("FAIL b2b_stall_hold got %0d changes need 0", stall_err); end
        tests++; if (len_q.size() != 2) begin fails++; $display("FAIL b2b_len_pulses got %0d need 2", len_q.size()); end
        else begin
            tests++; if (len_q[0] !== {32'd3, 8'd13}) begin fails++; $display("FAIL b2b_len0 got %h need %h", len_q[0], {32'd3, 8'd13}); end
            tests++; if (len_q[1] !== {32'd17, 8'd15}) begin fails++; $display("FAIL b2b_len1 got %h need %h", len_q[1], {32'd17, 8'd15}); end
        end
    endtask

    task automatic test_reset_mid_pad();
        beat_t act;
        in_q.delete(); exp_q.delete();
        in_q.push_back({1'b0, 32'h51});
        in_q.push_back({1'b1, 32'h52});
        drive(1'b0, 5, 1'b0, 0);
        tests++; if (out_q.size() != 5 || out_q[4] !== {1'b0, 32'h0}) begin
            fails++; $display("FAIL rstpad_pre beats %0d got last %h need 5 beats ending %h", out_q.size(), (out_q.size() > 0) ? out_q[out_q.size()-1] : 33'h0, {1'b0, 32'h0});
        end
        @(negedge clk);
        rst = 1'b1; a_s_tvalid = 1'b0; a_m_tready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (a_m_tvalid !== 1'b0) begin fails++; $display("FAIL rstpad_m_tvalid got %b need 0", a_m_tvalid); end
        tests++; if (a_s_tready !== 1'b1) begin fails++; $display("FAIL rstpad_s_tready got %b need 1", a_s_tready); end
        tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL rstpad_busy got %b need 0", a_busy); end
        for (int i = 1; i <= 16; i++) begin
            in_q.push_back({(i == 16), 32'h600 + 32'(i)});
            exp_q.push_back({(i == 16), 32'h600 + 32'(i)});
        end
        drive(1'b0, 16, 1'b0, 4);
        tests++; if (out_q.size() != 16) begin fails++; $display("FAIL rstpad_count got %0d need 16", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            act = 'x; if (i < out_q.size()) act = out_q[i];
            tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL rstpad_beat%0d got %h need %h", i, act, exp_q[i]); end
        end
        tests++; if (len_q.size() != 1 || len_q[0] !== {32'd16, 8'd0}) begin
            fails++; $display("FAIL rstpad_len pulses %0d got %h need %h", len_q.size(), (len_q.size() > 0) ? len_q[0] : 40'h0, {32'd16, 8'd0});
        end
    endtask

    task automatic test_burst_len_one();
        beat_t act;
        in_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            in_q.push_back({(i == 3), 32'h40 + 32'(i)});
            exp_q.push_back({(i == 3), 32'h40 + 32'(i)});
        end
        drive(1'b1, 4, 1'b0, 3);
        tests++; if (out_q.size() != 4) begin fails++; $display("FAIL bl1_count got %0d need 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            act = 'x; if (i < out_q.size()) act = out_q[i];
            tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL bl1_beat%0d got %h need %h", i, act, exp_q[i]); end
        end
        tests++; if (len_q.size() != 1 || len_q[0] !== {32'd4, 8'd0}) begin
            fails++; $display("FAIL bl1_len pulses %0d got %h need %h", len_q.size(), (len_q.size() > 0) ? len_q[0] : 40'h0, {32'd4, 8'd0});
        end
        tests++; if (low_cnt != 0) begin fails++; $display("FAIL bl1_pad_cycles got %0d need 0", low_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout tests %0d", tests);
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        a_s_tdata = '0; a_s_tlast = 1'b0; a_s_tvalid = 1'b0; a_m_tready = 1'b1;
        b_s_tdata = '0; b_s_tlast = 1'b0; b_s_tvalid = 1'b0; b_m_tready = 1'b1;
        test_reset();
        test_full_burst();
        test_short_pad();
        test_two_bursts();
        test_back_to_back();
        test_reset_mid_pad();
        test_burst_len_one();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
